// File: rtl/alu_core_pkg.sv
// rtl/alu_core_pkg.sv - opcode constants, data width and rotate helpers shared by the ALU
package alu_core_pkg;

    localparam int DATA_W = 32;
    localparam int RES_W  = 2 * DATA_W;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHRA = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_MUL  = 5'd9;
    localparam logic [4:0] OP_DIV  = 5'd10;
    localparam logic [4:0] OP_NEG  = 5'd11;
    localparam logic [4:0] OP_NOT  = 5'd12;

    // Rotates shift a doubled copy of the word so the wrapped bits fall into place.
    function automatic logic [DATA_W-1:0] rotate_right(input logic [DATA_W-1:0] value,
                                                       input logic [4:0] amount);
        logic [RES_W-1:0] doubled;
        doubled = {value, value} >> amount;
        return doubled[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] rotate_left(input logic [DATA_W-1:0] value,
                                                      input logic [4:0] amount);
        logic [RES_W-1:0] doubled;
        doubled = {value, value} << amount;
        return doubled[RES_W-1:DATA_W];
    endfunction

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - combinational signed 32/32 divider, quotient toward zero
module alu_divider
    import alu_core_pkg::*;
(
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic              dividend_neg;
    logic              divisor_neg;
    logic [DATA_W-1:0] dividend_mag;
    logic [DATA_W-1:0] divisor_mag;
    logic [DATA_W-1:0] divisor_safe;
    logic [DATA_W-1:0] quotient_mag;
    logic [DATA_W-1:0] remainder_mag;

    // Unsigned magnitudes make -2^31 / -1 come out as 0x8000_0000 with no special case.
    always_comb begin
        dividend_neg  = dividend[DATA_W-1];
        divisor_neg   = divisor[DATA_W-1];
        dividend_mag  = dividend_neg ? (~dividend + 1'b1) : dividend;
        divisor_mag   = divisor_neg ? (~divisor + 1'b1) : divisor;
        divisor_safe  = (divisor == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : divisor_mag;
        quotient_mag  = dividend_mag / divisor_safe;
        remainder_mag = dividend_mag % divisor_safe;
        if (divisor == '0) begin
            quotient  = '0;
            remainder = '0;
        end else begin
            quotient  = (dividend_neg ^ divisor_neg) ? (~quotient_mag + 1'b1) : quotient_mag;
            remainder = dividend_neg ? (~remainder_mag + 1'b1) : remainder_mag;
        end
    end

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - single-cycle 32-bit ALU with registered 64-bit HI/LO result
module alu_core
    import alu_core_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] input_a,
    input  logic [DATA_W-1:0] input_b,
    input  logic [4:0]        opcode,
    output logic [RES_W-1:0]  alu_result
);

    logic [4:0]        shift_amount;
    logic [DATA_W-1:0] div_quotient;
    logic [DATA_W-1:0] div_remainder;
    logic [RES_W-1:0]  product;
    logic [RES_W-1:0]  next_result;

    assign shift_amount = input_b[4:0];
    assign product      = $signed(input_a) * $signed(input_b);

    alu_divider u_divider (
        .dividend  (input_a),
        .divisor   (input_b),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    always_comb begin
        next_result = '0;
        case (opcode)
            OP_ADD:  next_result[DATA_W-1:0] = input_a + input_b;
            OP_SUB:  next_result[DATA_W-1:0] = input_a - input_b;
            OP_AND:  next_result[DATA_W-1:0] = input_a & input_b;
            OP_OR:   next_result[DATA_W-1:0] = input_a | input_b;
            OP_SHR:  next_result[DATA_W-1:0] = input_a >> shift_amount;
            OP_SHRA: next_result[DATA_W-1:0] = $signed(input_a) >>> shift_amount;
            OP_SHL:  next_result[DATA_W-1:0] = input_a << shift_amount;
            OP_ROR:  next_result[DATA_W-1:0] = rotate_right(input_a, shift_amount);
            OP_ROL:  next_result[DATA_W-1:0] = rotate_left(input_a, shift_amount);
            OP_MUL:  next_result = product;
            OP_DIV:  next_result = {div_remainder, div_quotient};
            OP_NEG:  next_result[DATA_W-1:0] = ~input_a + 1'b1;
            OP_NOT:  next_result[DATA_W-1:0] = ~input_a;
            default: next_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            alu_result <= '0;
        end else begin
            alu_result <= next_result;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - scoreboard bench for alu_core driven by hand-computed directed vectors
module tb_alu_core;

    typedef struct {
        string       name;
        logic [63:0] value;
    } expect_t;

    logic        clk;
    logic        clr;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [4:0]  opcode;
    logic [63:0] alu_result;

    expect_t expect_q[$];
    int      checks;
    int      errors;

    alu_core dut (
        .clk        (clk),
        .clr        (clr),
        .input_a    (input_a),
        .input_b    (input_b),
        .opcode     (opcode),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input string name, input logic c, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_value);
        expect_t e;
        @(negedge clk);
        clr     = c;
        opcode  = op;
        input_a = a;
        input_b = b;
        e.name  = name;
        e.value = exp_value;
        expect_q.push_back(e);
    endtask

    // Monitor: the result registered at an edge belongs to the oldest pending expectation.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expect_q.size() > 0) begin
                e = expect_q.pop_front();
                checks++;
                if (alu_result !== e.value) begin
                    errors++;
                    $display("FAIL %s: got 0x%016h expected 0x%016h", e.name, alu_result, e.value);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        checks  = 0;
        errors  = 0;
        clr     = 1'b1;
        opcode  = 5'd0;
        input_a = 32'd0;
        input_b = 32'd0;

        issue("reset_with_add", 1'b1, 5'd0, 32'd2, 32'd3, 64'h0);
        issue("first_after_reset", 1'b0, 5'd0, 32'd2, 32'd3, 64'h0000_0000_0000_0005);
        issue("sub_wrap", 1'b0, 5'd1, 32'd2, 32'd3, 64'h0000_0000_FFFF_FFFF);
        issue("add_overflow", 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0000_0000_0001);
        issue("and", 1'b0, 5'd2, 32'd12, 32'd17, 64'h0);
        issue("or", 1'b0, 5'd3, 32'd17, 32'd20, 64'h15);
        issue("shr", 1'b0, 5'd4, 32'd17, 32'd17, 64'h0);
        issue("shra_neg", 1'b0, 5'd5, 32'h8000_0000, 32'd4, 64'h0000_0000_F800_0000);
        issue("shra_upper_b_ignored", 1'b0, 5'd5, 32'h8000_0000, 32'h0000_0024, 64'h0000_0000_F800_0000);
        issue("shl_31", 1'b0, 5'd6, 32'd1, 32'd31, 64'h0000_0000_8000_0000);
        issue("shl_amount_zero", 1'b0, 5'd6, 32'h0000_1234, 32'd32, 64'h0000_0000_0000_1234);
        issue("ror", 1'b0, 5'd7, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
        issue("rol", 1'b0, 5'd8, 32'h8000_0001, 32'd1, 64'h0000_0000_0000_0003);
        issue("ror_amount_zero", 1'b0, 5'd7, 32'h8000_0001, 32'hFFFF_FFE0, 64'h0000_0000_8000_0001);
        issue("mul_pos", 1'b0, 5'd9, 32'd17, 32'd17, 64'h121);
        issue("mul_neg", 1'b0, 5'd9, 32'hFFFF_FFFA, 32'd5, 64'hFFFF_FFFF_FFFF_FFE2);
        issue("div_pos", 1'b0, 5'd10, 32'd17, 32'd17, 64'h0000_0000_0000_0001);
        issue("div_neg_pos", 1'b0, 5'd10, 32'hFFFF_FFFA, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        issue("div_neg_neg", 1'b0, 5'd10, 32'hFFFF_FFEF, 32'hFFFF_FFF7, 64'hFFFF_FFF8_0000_0001);
        issue("div_small", 1'b0, 5'd10, 32'd8, 32'd24, 64'h0000_0008_0000_0000);
        issue("div_by_zero", 1'b0, 5'd10, 32'd5, 32'd0, 64'h0);
        issue("div_min_by_m1", 1'b0, 5'd10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        issue("neg", 1'b0, 5'd11, 32'd5, 32'd0, 64'h0000_0000_FFFF_FFFB);
        issue("not", 1'b0, 5'd12, 32'd0, 32'd7, 64'h0000_0000_FFFF_FFFF);
        issue("op13_zero", 1'b0, 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);
        issue("op31_zero", 1'b0, 5'd31, 32'd9, 32'd9, 64'h0);
        issue("mid_stream_clr", 1'b1, 5'd9, 32'hFFFF_FFFA, 32'd5, 64'h0);
        issue("resume_after_clr", 1'b0, 5'd0, 32'd2, 32'd3, 64'h0000_0000_0000_0005);

        wait_cycles = 0;
        while (expect_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (expect_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", expect_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits in, 64 bits out.
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  input  1  single clock, all state updates on rising edge.
- clr  input  1  reset, synchronous, active-high.
- input_a  input  32  operand A (two's complement where signed).
- input_b  input  32  operand B / shift-rotate amount source.
- opcode  input  5  operation select.
- alu_result  output  64  registered result; [63:32] HI, [31:0] LO.
REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 SHALL compute combinationally from input_a, input_b and opcode, then register into alu_result on the next rising clk edge.
- Latency: exactly 1 cycle.
- No handshake; a new operation is accepted every cycle.
REQ-005 Opcode map (HI = 0 unless stated):
- 0 ADD: LO = A+B mod 2^32.
- 1 SUB: LO = A-B mod 2^32.
- 2 AND: LO = A&B.
- 3 OR: LO = A|B.
- 4 SHR: LO = A logical right by B[4:0].
- 5 SHRA: LO = A arithmetic right by B[4:0].
- 6 SHL: LO = A left by B[4:0].
- 7 ROR: LO = A rotated right by B[4:0].
- 8 ROL: LO = A rotated left by B[4:0].
- 9 MUL: {HI,LO} = signed 64-bit product A*B.
- 10 DIV: LO = signed quotient A/B, truncated toward zero; HI = remainder, sign of dividend.
- 11 NEG: LO = -A.
- 12 NOT: LO = ~A.
- 13-31: alu_result = 0.
REQ-006 Shift/rotate SHALL use only B[4:0]; B[31:5] ignored; amount 0 returns A unchanged.
REQ-007 ADD/SUB overflow and carry SHALL be discarded; no flag outputs.
REQ-008 DIV with B = 0 SHALL give alu_result = 0.
REQ-009 DIV with A = 0x8000_0000, B = 0xFFFF_FFFF SHALL give LO = 0x8000_0000, HI = 0.
REQ-010 Operand changes between edges SHALL have no effect until the next edge.

Reset
REQ-011 clr high at a rising edge SHALL force alu_result to 0, overriding any operation.
REQ-012 The first edge with clr low SHALL register the current operation normally.
REQ-013 Asserting clr mid-stream SHALL discard the in-flight result; no other state exists.

Structure
REQ-014 A shared package SHALL hold the 5-bit opcode constants (values 0-12) and the data-width constant 32.
REQ-015 A combinational sub-module alu_divider (signed 32/32 -> quotient, remainder) is the natural split; all other operations stay inline.

Verification
REQ-016 A=2, B=3: op0 -> 0x0000_0000_0000_0005; op1 -> 0x0000_0000_FFFF_FFFF.
REQ-017 A=12, B=17: op2 -> 0x0; A=17, B=20: op3 -> 0x15; A=17, B=17: op4 -> 0x0.
REQ-018 A=17, B=17: op9 -> 0x121; op10 -> HI=0, LO=1.
REQ-019 DIV signed cases:
- A=-6, B=5 -> LO=0xFFFF_FFFF, HI=0xFFFF_FFFF.
- A=-17, B=-9 -> LO=1, HI=0xFFFF_FFF8.
- A=8, B=24 -> LO=0, HI=8.
- B=0 -> 0.
REQ-020 MUL A=-6, B=5 -> 0xFFFF_FFFF_FFFF_FFE2.
REQ-021 Rotate: A=0x8000_0001, B=1: op8 -> LO=0x0000_0003; op7 -> LO=0xC000_0000.
REQ-022 Reset: clr high with op0 active -> alu_result = 0 that cycle; each result appears one edge after its operands.
